// File: rtl/hidden_layer_ctrl.sv
// hidden_layer_ctrl
// -----------------
// Sequencer for one fully-connected hidden layer. For every neuron n it
// streams N_INPUTS (activation, weight) pairs out of external synchronous
// memories, multiply-accumulates them, adds the left-aligned bias, then writes
// relu + saturate of the rescaled sum to the output-activation RAM.
//
// Ports
//   clk, rst_n      : clock (rising edge) and asynchronous active-low reset
//   start, abort    : pass request (taken only in IDLE) / synchronous cancel
//   busy, done      : busy in every state except IDLE; done is a 1-cycle pulse
//   in_addr/in_data : activation RAM; data valid one cycle after the address
//   w_addr/w_data   : weight ROM; data valid one cycle after the address
//   b_addr/b_data   : bias ROM indexed by the neuron, combinational data
//   out_we/out_addr/out_data : output activation write port
//
// Per-neuron schedule is N_INPUTS MAC cycles + DRAIN + BIAS + WRITE, followed
// by a single DONE cycle at the end of the layer. ACC_W must satisfy
// ACC_W >= 2*DATA_W + clog2(N_INPUTS) + 1 so that full-scale sums never wrap.
module hidden_layer_ctrl #(
  parameter int N_NEURONS = 30,
  parameter int N_INPUTS  = 784,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 32,
  parameter int FRAC_BITS = 4,
  localparam int IN_AW    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
  localparam int W_AW     = (N_NEURONS * N_INPUTS > 1) ? $clog2(N_NEURONS * N_INPUTS) : 1,
  localparam int N_AW     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [IN_AW-1:0]         in_addr,
  input  logic signed [DATA_W-1:0] in_data,
  output logic [W_AW-1:0]          w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  output logic [N_AW-1:0]          b_addr,
  input  logic signed [DATA_W-1:0] b_data,
  output logic                     out_we,
  output logic [N_AW-1:0]          out_addr,
  output logic signed [DATA_W-1:0] out_data
);

  localparam int PROD_W = 2 * DATA_W;

  localparam logic [IN_AW-1:0] J_LAST = IN_AW'(N_INPUTS - 1);
  localparam logic [N_AW-1:0]  N_LAST = N_AW'(N_NEURONS - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC   = 3'd1,
    DRAIN = 3'd2,
    BIAS  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                    state_reg;
  logic [N_AW-1:0]           n_reg;
  logic [IN_AW-1:0]          j_reg;
  logic [W_AW-1:0]           w_addr_reg;
  logic signed [ACC_W-1:0]   acc_reg;
  // Set when the previous cycle issued an address, i.e. the memories are
  // presenting a pair this cycle that must be accumulated.
  logic                      mac_valid_reg;
  logic                      busy_reg;
  logic                      done_reg;
  logic                      out_we_reg;
  logic [N_AW-1:0]           out_addr_reg;
  logic signed [DATA_W-1:0]  out_data_reg;

  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_mac;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   acc_bias;
  logic signed [ACC_W-1:0]   scaled;
  logic signed [DATA_W-1:0]  act_next;

  // Datapath: full-precision product, explicit sign extension into the
  // accumulator, bias aligned to the fixed-point position.
  always_comb begin
    prod     = in_data * w_data;
    prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    acc_mac  = mac_valid_reg ? (acc_reg + prod_ext) : acc_reg;
    bias_ext = {{(ACC_W - DATA_W){b_data[DATA_W-1]}}, b_data} <<< FRAC_BITS;
    acc_bias = acc_reg + bias_ext;
    scaled   = acc_bias >>> FRAC_BITS;
    if (scaled[ACC_W-1]) begin
      act_next = '0;
    end else if (scaled > OUT_MAX) begin
      act_next = OUT_MAX[DATA_W-1:0];
    end else begin
      act_next = scaled[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      n_reg         <= '0;
      j_reg         <= '0;
      w_addr_reg    <= '0;
      acc_reg       <= '0;
      mac_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      out_we_reg    <= 1'b0;
      out_addr_reg  <= '0;
      out_data_reg  <= '0;
    end else begin
      done_reg   <= 1'b0;
      out_we_reg <= 1'b0;
      if (abort && (state_reg != IDLE)) begin
        state_reg     <= IDLE;
        busy_reg      <= 1'b0;
        mac_valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              n_reg         <= '0;
              j_reg         <= '0;
              w_addr_reg    <= '0;
              acc_reg       <= '0;
              mac_valid_reg <= 1'b0;
              busy_reg      <= 1'b1;
              state_reg     <= MAC;
            end
          end
          MAC: begin
            acc_reg       <= acc_mac;
            mac_valid_reg <= 1'b1;
            if (j_reg == J_LAST) begin
              // Addresses stay on the last pair until the next neuron.
              state_reg <= DRAIN;
            end else begin
              j_reg      <= j_reg + IN_AW'(1);
              w_addr_reg <= w_addr_reg + W_AW'(1);
            end
          end
          DRAIN: begin
            acc_reg       <= acc_mac;
            mac_valid_reg <= 1'b0;
            state_reg     <= BIAS;
          end
          BIAS: begin
            // The result is registered here so that out_we is high
            // exactly while the FSM sits in WRITE.
            acc_reg      <= acc_bias;
            out_we_reg   <= 1'b1;
            out_addr_reg <= n_reg;
            out_data_reg <= act_next;
            state_reg    <= WRITE;
          end
          WRITE: begin
            if (n_reg == N_LAST) begin
              state_reg <= DONE;
            end else begin
              n_reg      <= n_reg + N_AW'(1);
              j_reg      <= '0;
              acc_reg    <= '0;
              // The weight address already points at n*N_INPUTS+N_INPUTS-1.
              w_addr_reg <= w_addr_reg + W_AW'(1);
              state_reg  <= MAC;
            end
          end
          DONE: begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
          default: begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign in_addr  = j_reg;
  assign w_addr   = w_addr_reg;
  assign b_addr   = n_reg;
  assign out_we   = out_we_reg;
  assign out_addr = out_addr_reg;
  assign out_data = out_data_reg;

endmodule

// File: doc/hidden_layer_ctrl.md
HIDDEN_LAYER_CTRL -- requirements
Module: hidden_layer_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- N_NEURONS, 30, hidden-layer neuron count
- N_INPUTS, 784, inputs per neuron
- DATA_W, 8, signed width of activation, weight, bias and output
- ACC_W, 32, signed accumulator width
- FRAC_BITS, 4, fractional bits of the fixed-point format
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on the rising edge
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, request one full layer pass
- abort, in, 1, synchronous cancel of the current pass
- busy, out, 1, high from start acceptance until return to IDLE
- done, out, 1, one-cycle pulse at pass completion
- in_addr, out, clog2(N_INPUTS), input-activation RAM read address
- in_data, in, DATA_W, signed activation, valid 1 cycle after in_addr
- w_addr, out, clog2(N_NEURONS*N_INPUTS), weight ROM address
- w_data, in, DATA_W, signed weight, valid 1 cycle after w_addr
- b_addr, out, clog2(N_NEURONS), bias ROM address, equal to the current neuron index
- b_data, in, DATA_W, signed bias, stable while b_addr is stable
- out_we, out, 1, output-activation write strobe
- out_addr, out, clog2(N_NEURONS), output write address
- out_data, out, DATA_W, output activation

Function
REQ-003 The FSM SHALL have the states IDLE, MAC, DRAIN, BIAS, WRITE and DONE.
REQ-004 In IDLE, start=1 SHALL be accepted at that edge: clear the neuron index n, the input index j and acc, then go to MAC.
REQ-005 Start SHALL be ignored in every state except IDLE.
REQ-006 In MAC, each cycle SHALL drive in_addr=j and w_addr=n*N_INPUTS+j, then increment j.
- After j=N_INPUTS-1 is issued, the FSM SHALL go to DRAIN.
REQ-007 Each cycle after an address was issued in MAC, the block SHALL perform acc <= acc + in_data*w_data.
- The product is full-precision 2*DATA_W, sign-extended to ACC_W.
- This includes the DRAIN cycle, which consumes the last returned pair.
REQ-008 In BIAS, the block SHALL perform acc <= acc + (sign-extended b_data <<< FRAC_BITS).
REQ-009 In WRITE, the block SHALL drive out_we=1 for exactly one cycle with out_addr=n and out_data=sat(relu(acc >>> FRAC_BITS)).
- relu: negative becomes 0.
- sat: values above 2^(DATA_W-1)-1 clamp to 2^(DATA_W-1)-1.
REQ-010 After WRITE:
- if n<N_NEURONS-1: n increments, j and acc clear, next state MAC;
- otherwise next state DONE.
REQ-011 DONE SHALL assert done=1 for one cycle, then go to IDLE.
REQ-012 Latency: done SHALL be high exactly N_NEURONS*(N_INPUTS+3)+1 cycles after the start-accept edge (23611 cycles at default parameters).
REQ-013 busy SHALL be 1 in every state except IDLE.
REQ-014 abort=1 in any non-IDLE state SHALL force IDLE at that edge: no done, no further out_we. Abort has priority over all other transitions.
REQ-015 out_we SHALL never be asserted outside WRITE.
REQ-016 Addresses SHALL hold their last value outside MAC. No read-enable is required.
REQ-017 acc SHALL NOT wrap for full-scale inputs: ACC_W >= 2*DATA_W + clog2(N_INPUTS) + 1.

Reset
REQ-018 rst_n=0 SHALL asynchronously force:
- state=IDLE;
- busy=0, done=0, out_we=0;
- all addresses, n, j, acc and out_data to 0.
REQ-019 Reset asserted mid-pass SHALL abandon the pass without a done pulse; the next start SHALL run a complete pass.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Params N_NEURONS=2, N_INPUTS=4, FRAC_BITS=0; all activations 1, all weights 2, biases {3,-20} -> out writes (0,11) then (1,0); done 15 cycles after accept.
- Default params; all activations 127, all weights 127, bias 127 -> every one of the 30 writes has out_data=127 (saturated); done at cycle 23611.
- Start pulsed again during MAC of neuron 0 -> ignored; exactly N_NEURONS writes and one done.
- Abort asserted in neuron 1 MAC -> busy=0 next cycle; no further out_we; no done.
- rst_n low during WRITE -> out_we=0 immediately; a fresh start completes correctly.
- Address trace check: w_addr sequence 0..N_NEURONS*N_INPUTS-1 with no gaps; in_addr repeats 0..N_INPUTS-1 per neuron.
